// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: word type, frame layout and sizing constants.
package icache_pkg;

    localparam int WORD_W          = 32;
    localparam int WORDADDR_W      = 30;
    localparam int DEFAULT_NFRAMES = 16;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [WORDADDR_W-1:0] tagfield_t;

    // Tag field is wide enough for any frame count; unused upper bits stay zero.
    typedef struct packed {
        logic      valid;
        tagfield_t tag;
        word_t     data;
    } icache_frame_t;

    // Drops the byte offset so memory always sees a word-aligned address.
    function automatic word_t wordAlign(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Instruction-side bundle: datapath request/response plus the memory read port.
import icache_pkg::*;

interface icache_if;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one word per frame and a two-state fill FSM.
module icache
    import icache_pkg::*;
#(
    parameter int NFRAMES = DEFAULT_NFRAMES
) (
    input  logic     CLK,
    input  logic     RST,
    icache_if.slave  cif
);

    localparam int IDX_W = $clog2(NFRAMES);

    typedef enum logic {IDLE, FILL} state_t;

    state_t          state;
    icache_frame_t   frames [NFRAMES];
    word_t           missAddr;
    logic            iRen;

    logic [IDX_W-1:0] reqIdx;
    logic [IDX_W-1:0] missIdx;
    tagfield_t        reqTag;
    tagfield_t        missTag;
    icache_frame_t    reqFrame;
    logic             hit;

    // Split request and miss addresses into index/tag and look up the addressed frame.
    always_comb begin
        reqIdx   = cif.imemaddr[2 +: IDX_W];
        reqTag   = tagfield_t'(cif.imemaddr[WORD_W-1:2+IDX_W]);
        missIdx  = missAddr[2 +: IDX_W];
        missTag  = tagfield_t'(missAddr[WORD_W-1:2+IDX_W]);
        reqFrame = frames[reqIdx];
        hit      = (state == IDLE) && cif.imemREN && reqFrame.valid
                   && (reqFrame.tag == reqTag);
    end

    assign cif.ihit     = hit;
    assign cif.imemload = hit ? reqFrame.data : '0;
    assign cif.iREN     = iRen;
    assign cif.iaddr    = missAddr;

    // Miss handling: latch the aligned address, hold the read until memory answers, then fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            iRen     <= 1'b0;
            missAddr <= '0;
            for (int i = 0; i < NFRAMES; i++) begin
                frames[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (cif.imemREN && !hit) begin
                        missAddr <= wordAlign(cif.imemaddr);
                        iRen     <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (!cif.iwait) begin
                        frames[missIdx] <= '{valid: 1'b1, tag: missTag, data: cif.iload};
                        iRen            <= 1'b0;
                        missAddr        <= '0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold misses, wait-stated fills, hits, conflicts, mid-fill changes and reset.
`timescale 1ns/1ps
import icache_pkg::*;

module tb_icache;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   totalCount = 0;
    int   passCount  = 0;

    icache_if cif();

    icache #(.NFRAMES(16)) dut (
        .CLK (CLK),
        .RST (RST),
        .cif (cif)
    );

    // Free-running 10 ns clock.
    always #5 CLK = ~CLK;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ren, input word_t addr);
        cif.imemREN  = ren;
        cif.imemaddr = addr;
    endtask

    task automatic checkOutput(input string tag, input logic expHit, input word_t expLoad,
                               input logic expRen, input word_t expAddr);
        @(negedge CLK);
        totalCount++;
        assert (cif.ihit === expHit) passCount++;
        else $error("[TB] FAIL %s ihit observed %b expected %b", tag, cif.ihit, expHit);
        totalCount++;
        assert (cif.imemload === expLoad) passCount++;
        else $error("[TB] FAIL %s imemload observed %h expected %h", tag, cif.imemload, expLoad);
        totalCount++;
        assert (cif.iREN === expRen) passCount++;
        else $error("[TB] FAIL %s iREN observed %b expected %b", tag, cif.iREN, expRen);
        totalCount++;
        assert (cif.iaddr === expAddr) passCount++;
        else $error("[TB] FAIL %s iaddr observed %h expected %h", tag, cif.iaddr, expAddr);
    endtask

    // Request addr in the current cycle, expect a miss, serve it after waits busy cycles,
    // then expect the hit on the cycle after the fill.
    task automatic doMiss(input string tag, input word_t addr, input int waits, input word_t data);
        word_t aligned;
        aligned = {addr[31:2], 2'b00};
        applyStimulus(1'b1, addr);
        cif.iwait = 1'b1;
        checkOutput({tag, "-miss"}, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < waits; i++) begin
            nextCycle();
            cif.iwait = 1'b1;
            checkOutput({tag, "-wait"}, 1'b0, 32'h0, 1'b1, aligned);
        end
        nextCycle();
        cif.iwait = 1'b0;
        cif.iload = data;
        checkOutput({tag, "-fill"}, 1'b0, 32'h0, 1'b1, aligned);
        nextCycle();
        cif.iwait = 1'b1;
        cif.iload = 32'h0;
        checkOutput({tag, "-hit"}, 1'b1, data, 1'b0, 32'h0);
    endtask

    initial begin
        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0;
        cif.iwait    = 1'b1;
        cif.iload    = 32'h0;

        $display("[TB] reset with a pending request to address 0");
        nextCycle();
        nextCycle();
        checkOutput("reset", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] address 0 must miss until filled");
        nextCycle();
        RST = 1'b0;
        doMiss("addr0", 32'h0000_0000, 0, 32'hDEAD_0000);

        $display("[TB] 0x40 with three wait cycles");
        nextCycle();
        doMiss("miss40", 32'h0000_0040, 3, 32'h2001_0005);

        nextCycle();
        applyStimulus(1'b1, 32'h0000_0040);
        checkOutput("rehit40", 1'b1, 32'h2001_0005, 1'b0, 32'h0);

        nextCycle();
        applyStimulus(1'b1, 32'h0000_0043);
        checkOutput("offset43", 1'b1, 32'h2001_0005, 1'b0, 32'h0);

        $display("[TB] no request leaves the cache idle");
        nextCycle();
        applyStimulus(1'b0, 32'h0000_0080);
        checkOutput("noreq1", 1'b0, 32'h0, 1'b0, 32'h0);
        nextCycle();
        checkOutput("noreq2", 1'b0, 32'h0, 1'b0, 32'h0);

        $display("[TB] conflict: 0x80 evicts 0x40");
        nextCycle();
        doMiss("miss80", 32'h0000_0080, 2, 32'hAAAA_0080);
        nextCycle();
        doMiss("remiss40", 32'h0000_0040, 0, 32'h2001_0005);

        $display("[TB] separate frame leaves 0x40 resident");
        nextCycle();
        doMiss("miss14", 32'h0000_0014, 1, 32'h5555_5555);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0040);
        checkOutput("still40", 1'b1, 32'h2001_0005, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0014);
        checkOutput("still14", 1'b1, 32'h5555_5555, 1'b0, 32'h0);

        $display("[TB] reset in the middle of a fill");
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0080);
        checkOutput("rstfill-miss", 1'b0, 32'h0, 1'b0, 32'h0);
        nextCycle();
        cif.iwait = 1'b1;
        checkOutput("rstfill-wait", 1'b0, 32'h0, 1'b1, 32'h0000_0080);
        RST       = 1'b1;
        cif.iwait = 1'b0;
        cif.iload = 32'h0BAD_0BAD;
        nextCycle();
        RST       = 1'b0;
        cif.iwait = 1'b1;
        cif.iload = 32'h0;
        applyStimulus(1'b0, 32'h0000_0080);
        checkOutput("rstfill-after", 1'b0, 32'h0, 1'b0, 32'h0);
        nextCycle();
        doMiss("rst40", 32'h0000_0040, 1, 32'h2001_0005);

        $display("[TB] address change during a fill");
        nextCycle();
        doMiss("miss100", 32'h0000_0100, 0, 32'h0100_0100);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0040);
        checkOutput("mid-miss40", 1'b0, 32'h0, 1'b0, 32'h0);
        nextCycle();
        applyStimulus(1'b1, 32'h0000_0100);
        cif.iwait = 1'b1;
        checkOutput("mid-wait", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        nextCycle();
        applyStimulus(1'b0, 32'h0000_0100);
        cif.iwait = 1'b0;
        cif.iload = 32'h2001_0005;
        checkOutput("mid-fill", 1'b0, 32'h0, 1'b1, 32'h0000_0040);
        nextCycle();
        cif.iwait = 1'b1;
        cif.iload = 32'h0;
        applyStimulus(1'b1, 32'h0000_0040);
        checkOutput("mid-hit40", 1'b1, 32'h2001_0005, 1'b0, 32'h0);
        nextCycle();
        doMiss("mid-miss100", 32'h0000_0100, 0, 32'h0100_0100);

        nextCycle();
        applyStimulus(1'b0, 32'h0);
        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 The block SHALL take parameter NFRAMES, default 16, meaning the number of direct-mapped frames, one 32-bit word per frame.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port imemREN, input, 1 bit: the datapath requests an instruction.
REQ-005 The block SHALL have port imemaddr, input, 32 bits: the instruction byte address from the datapath.
REQ-006 The block SHALL have port ihit, output, 1 bit: imemload is valid this cycle.
REQ-007 The block SHALL have port imemload, output, 32 bits: the instruction word returned to the datapath.
REQ-008 The block SHALL have port iREN, output, 1 bit: read request to the memory controller.
REQ-009 The block SHALL have port iaddr, output, 32 bits: the word-aligned read address sent to memory.
REQ-010 The block SHALL have port iwait, input, 1 bit: memory busy; a low value while iREN is high means iload is valid.
REQ-011 The block SHALL have port iload, input, 32 bits: the word returned from memory.

Function
REQ-012 Address split SHALL be: byte offset = imemaddr[1:0] (ignored); index = imemaddr[2+log2(NFRAMES)-1:2]; tag = remaining upper bits.
REQ-013 Each frame SHALL hold a valid bit, a tag and a 32-bit data word.
REQ-014 The FSM SHALL have two states: IDLE and FILL.
REQ-015 In IDLE, ihit SHALL be combinational and equal to imemREN AND (indexed frame valid) AND (stored tag == address tag), with zero-cycle latency.
REQ-016 On a hit, imemload SHALL equal the indexed frame data.
REQ-017 Whenever ihit = 0, imemload SHALL be 32'h0.
REQ-018 In IDLE, imemREN = 1 with no hit SHALL latch {imemaddr[31:2], 2'b00} into a miss-address register and move to FILL at the next edge.
REQ-019 In FILL, iREN SHALL be 1, iaddr SHALL equal the miss-address register, and ihit SHALL be 0.
REQ-020 In FILL with iwait = 0, the frame selected by the miss address SHALL be written at that edge: valid = 1, tag and data = iload; the FSM SHALL then return to IDLE.
REQ-021 In FILL with iwait = 1, the FSM SHALL stay in FILL with all outputs held.
REQ-022 Miss latency SHALL be (memory wait cycles + 1) cycles; the hit follows on the cycle after the fill via REQ-015.
REQ-023 In IDLE, iREN SHALL be 0 and iaddr SHALL be 32'h0.
REQ-024 A fill in progress SHALL complete even if imemREN or imemaddr change mid-FILL; the miss address is not re-sampled.
REQ-025 When imemREN = 0 in IDLE, the block SHALL issue no request and change no state.
REQ-026 A fill to an occupied frame SHALL overwrite it; there is no write-back because the cache is read-only.
REQ-027 The first word of memory (address 0) SHALL NOT hit after reset until filled, because valid bits gate the hit, not tag value 0.

Reset
REQ-028 RST high at a rising edge SHALL set state = IDLE, clear all valid bits and clear the miss-address register.
REQ-029 The frame data and tags SHALL be cleared by reset.
REQ-030 Outputs during and after reset SHALL be: ihit = 0 (no frame is valid), imemload = 0, iREN = 0, iaddr = 0.
REQ-031 Reset during FILL SHALL abandon the fill; no frame is written and iREN = 0 from the next cycle.

Structure
REQ-032 The frame type (valid, tag, data) and the index/tag width constants SHALL live in a shared package alongside cpu_types_pkg types; word_t SHALL be used for 32-bit words.
REQ-033 The state enum SHALL be local to icache.
REQ-034 No sub-module is needed: the frame array and FSM are a single module.
REQ-035 The block SHALL be the responder on the instruction half of datapath_cache_if and the initiator on the cache-to-memory instruction port.

Verification
REQ-036 Reset, then imemREN = 1, imemaddr = 0x0000_0040, memory iwait high for 3 cycles then iload = 0x2001_0005 -> iREN high for 4 cycles with iaddr = 0x40; ihit = 1 with imemload = 0x2001_0005 on the following cycle.
REQ-037 Re-request 0x0000_0040 -> ihit = 1 in the same cycle, iREN stays 0.
REQ-038 Request 0x0000_0080 (same index as 0x40, different tag) -> miss, fill, then a re-request of 0x40 misses again.
REQ-039 imemaddr = 0x0000_0043 after 0x40 has been filled -> hit with the same data (byte offset ignored).
REQ-040 Change imemaddr to 0x100 mid-FILL of 0x40 -> iaddr stays 0x40; frame 0x40 is filled; then 0x100 misses.
REQ-041 Assert RST mid-FILL -> next cycle iREN = 0 and state = IDLE; re-requesting 0x40 misses.
